// File: rtl/bp_pkg.sv
// Branch prediction shared definitions.
// Provides the counter reset value, the PC bit where the table index starts,
// the default index type and a helper that extracts the index from a PC.
package bp_pkg;

    localparam int unsigned BHT_INDEX_BITS = 6;
    localparam int unsigned BHT_PC_WIDTH   = 32;
    localparam int unsigned COUNTER_RESET  = 1;  // weakly not-taken
    localparam int unsigned BHT_INDEX_LSB  = 2;  // instructions are word aligned

    typedef logic [BHT_INDEX_BITS-1:0] bht_index_t;

    // Index = pc[BHT_INDEX_BITS+1:2]; upper PC bits alias onto the same entry.
    function automatic bht_index_t bht_index(input logic [BHT_PC_WIDTH-1:0] pc);
        return bht_index_t'(pc >> BHT_INDEX_LSB);
    endfunction

endpackage

// File: rtl/branch_history_table_sat_counter.sv
// Saturating up/down counter primitive.
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous, active-high; loads RESET_VALUE
//   i_count_up   - step up by one, holding at all-ones
//   i_count_down - step down by one, holding at zero
//   o_value      - current counter value
// Simultaneous up and down leaves the value unchanged.
module branch_history_table_sat_counter #(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned RESET_VALUE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_count_up,
    input  logic             i_count_down,
    output logic [WIDTH-1:0] o_value
);

    localparam logic [WIDTH-1:0] MaxValue   = '1;
    localparam logic [WIDTH-1:0] ResetValue = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_d;

    always_comb begin
        w_value_d = r_value;
        if (i_count_up && !i_count_down && (r_value != MaxValue)) begin
            w_value_d = r_value + 1'b1;
        end else if (i_count_down && !i_count_up && (r_value != '0)) begin
            w_value_d = r_value - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= ResetValue;
        end else begin
            r_value <= w_value_d;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: 2^INDEX_BITS saturating direction counters.
// Ports:
//   clk, reset             - clock (rising edge), asynchronous active-high reset
//   i_predict_valid/pc     - fetch lookup request
//   i_stall                - freezes the prediction output registers
//   o_predict_taken/ready  - registered prediction for the last accepted lookup
//   i_update_valid/pc      - resolved branch from execute
//   i_update_taken         - actual outcome, trains the entry
//   i_update_predicted     - prediction that was used for the branch
//   o_mispredict           - registered pulse on a mispredicted update
//   o_mispredict_count     - saturating mispredict statistic
module branch_history_table
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS    = 6,
    parameter int unsigned COUNTER_WIDTH = 2,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned STAT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_predict_valid,
    input  logic [XLEN-1:0]       i_predict_pc,
    input  logic                  i_stall,
    output logic                  o_predict_taken,
    output logic                  o_predict_ready,
    input  logic                  i_update_valid,
    input  logic [XLEN-1:0]       i_update_pc,
    input  logic                  i_update_taken,
    input  logic                  i_update_predicted,
    output logic                  o_mispredict,
    output logic [STAT_WIDTH-1:0] o_mispredict_count
);

    localparam int unsigned NumEntries = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0]    w_pred_idx;
    logic [INDEX_BITS-1:0]    w_upd_idx;
    logic [NumEntries-1:0]    w_write_en;
    logic [COUNTER_WIDTH-1:0] w_counter [NumEntries];
    logic [COUNTER_WIDTH-1:0] w_read_value;
    logic [COUNTER_WIDTH-1:0] w_fwd_value;
    logic                     w_mispredict_now;
    logic                     w_unused;

    logic                  r_predict_taken;
    logic                  r_predict_ready;
    logic                  r_mispredict;
    logic [STAT_WIDTH-1:0] r_mispredict_count;

    // Only the index bits of each PC matter; the rest are deliberately dropped.
    assign w_unused = ^{i_predict_pc, i_update_pc};

    generate
        if (INDEX_BITS == BHT_INDEX_BITS && XLEN == BHT_PC_WIDTH) begin : g_pkg_index
            assign w_pred_idx = bht_index(i_predict_pc);
            assign w_upd_idx  = bht_index(i_update_pc);
        end else begin : g_param_index
            assign w_pred_idx = i_predict_pc[BHT_INDEX_LSB +: INDEX_BITS];
            assign w_upd_idx  = i_update_pc[BHT_INDEX_LSB +: INDEX_BITS];
        end
    endgenerate

    always_comb begin
        w_write_en = '0;
        if (i_update_valid) begin
            w_write_en[w_upd_idx] = 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < NumEntries; g++) begin : g_entry
            branch_history_table_sat_counter #(
                .WIDTH       (COUNTER_WIDTH),
                .RESET_VALUE (COUNTER_RESET)
            ) u_counter (
                .clk          (clk),
                .reset        (reset),
                .i_count_up   (w_write_en[g] & i_update_taken),
                .i_count_down (w_write_en[g] & ~i_update_taken),
                .o_value      (w_counter[g])
            );
        end
    endgenerate

    assign w_read_value = w_counter[w_pred_idx];

    // A lookup that hits the entry being trained this edge sees the post-update
    // value, mirroring the counter's own saturating step.
    always_comb begin
        w_fwd_value = w_read_value;
        if (i_update_valid && (w_upd_idx == w_pred_idx)) begin
            if (i_update_taken) begin
                if (w_read_value != '1) begin
                    w_fwd_value = w_read_value + 1'b1;
                end
            end else begin
                if (w_read_value != '0) begin
                    w_fwd_value = w_read_value - 1'b1;
                end
            end
        end
    end

    assign w_mispredict_now = i_update_valid & (i_update_taken ^ i_update_predicted);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_predict_taken    <= 1'b0;
            r_predict_ready    <= 1'b0;
            r_mispredict       <= 1'b0;
            r_mispredict_count <= '0;
        end else begin
            if (!i_stall) begin
                r_predict_ready <= i_predict_valid;
                r_predict_taken <= i_predict_valid & w_fwd_value[COUNTER_WIDTH-1];
            end
            // Statistics are independent of fetch stalls.
            r_mispredict <= w_mispredict_now;
            if (w_mispredict_now && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

    assign o_predict_taken    = r_predict_taken;
    assign o_predict_ready    = r_predict_ready;
    assign o_mispredict       = r_mispredict;
    assign o_mispredict_count = r_mispredict_count;

endmodule
